sram_arbiter: RTL and testbench

- Shares one 32-bit asynchronous SRAM bank (base or ext RAM) between the CPU instruction-fetch port and the data-memory port.
- Sequences the SRAM control pins for reads and writes, with a configurable number of wait cycles.
- Returns a one-cycle acknowledge to the winning requester; the pipeline uses it to stall.
- Sits between THCOMIPS32e and the board SRAM pins in thinpad_top.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_select.sv | 59 +++++
 rtl/sram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM state encoding, access
// owner identifiers and the inactive levels of the active-low SRAM pins.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_e;

    // Inactive level of every active-low SRAM control and byte-enable bit.
    localparam logic CTRL_OFF    = 1'b1;
    localparam logic BE_N_OFF_BIT = 1'b1;

endpackage

// File: rtl/sram_arb_select.sv
// Grant selection between the fetch and data ports.
// Data wins by default. With SRAM_ARB_FAIR_EN defined, a saturating starve
// counter tracks data grants taken while a fetch waits, and once it reaches
// STARVE_LIMIT a contended grant goes to the fetch port instead.
module sram_arb_select
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic grant_valid_o,
    output logic grant_inst_o
);

    assign grant_valid_o = arb_en_i & (inst_req_i | data_req_i);

`ifdef SRAM_ARB_FAIR_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            force_inst;

    assign force_inst   = (starve_q == SC_MAX);
    assign grant_inst_o = inst_req_i & (~data_req_i | force_inst);

    // Next starve count: bump on a data grant that bypassed a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (grant_valid_o) begin
            if (grant_inst_o || !inst_req_i) begin
                starve_d = '0;
            end else if (starve_q != SC_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign grant_inst_o = inst_req_i & ~data_req_i;

    // Clock, reset and the limit only matter when fairness is built in.
    logic unused_fair;
    assign unused_fair = ^{clk, rst_n, 32'(STARVE_LIMIT)};
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter sharing one asynchronous 32-bit SRAM bank between the instruction
// fetch port and the data port. Data has priority; optional fetch fairness is
// enabled with the SRAM_ARB_FAIR_EN macro (see sram_arb_select).
// A grant latches the winner's access in IDLE; the following cycle launches
// the pin sequence, which is driven solely from the latched copy. DONE lasts
// one cycle and is the owner's acknowledge.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_ack,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_be,
    output logic                data_ack,
    output logic [DATA_W-1:0]   data_rdata,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_be_n,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic               launch_q, launch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    owner_e             owner_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;

    logic [DATA_W-1:0]  inst_rdata_q;
    logic [DATA_W-1:0]  data_rdata_q;

    logic               arb_en;
    logic               grant_valid;
    logic               grant_inst;
    logic               latch_en;
    logic               sample_en;
    logic               drive_en;

    // Arbitrate only in a genuinely idle cycle, not while a grant awaits launch.
    assign arb_en = (state_q == S_IDLE) && !launch_q;

    sram_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk           (clk),
        .rst_n         (rst_n),
        .arb_en_i      (arb_en),
        .inst_req_i    (inst_req),
        .data_req_i    (data_req),
        .grant_valid_o (grant_valid),
        .grant_inst_o  (grant_inst)
    );

    // Next-state logic: sequence the read or write phases and their wait counts.
    always_comb begin
        state_d   = state_q;
        launch_d  = 1'b0;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        sample_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (launch_q) begin
                    state_d = we_q ? S_WR_SETUP : S_READ;
                    cnt_d   = '0;
                end else if (grant_valid) begin
                    latch_en = 1'b1;
                    launch_d = 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    sample_en = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = '0;
            end
            S_WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM state, launch flag and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            launch_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            cnt_q    <= cnt_d;
        end
    end

    // Latch the winning access; requesters may change their inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_INST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (latch_en) begin
            if (grant_inst) begin
                owner_q <= OWN_INST;
                we_q    <= 1'b0;
                addr_q  <= inst_addr;
                wdata_q <= '0;
                be_q    <= '1;
            end else begin
                owner_q <= OWN_DATA;
                we_q    <= data_we;
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                be_q    <= data_be;
            end
        end
    end

    // Capture SRAM read data into the owner's register on the last READ edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else if (sample_en) begin
            if (owner_q == OWN_INST) begin
                inst_rdata_q <= ram_data;
            end else begin
                data_rdata_q <= ram_data;
            end
        end
    end

    // SRAM pin decode from the current state and the latched access.
    always_comb begin
        ram_ce_n = CTRL_OFF;
        ram_oe_n = CTRL_OFF;
        ram_we_n = CTRL_OFF;
        ram_be_n = {BE_W{BE_N_OFF_BIT}};
        drive_en = 1'b0;
        unique case (state_q)
            S_READ: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = '0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                ram_ce_n = 1'b0;
                ram_be_n = ~be_q;
                drive_en = 1'b1;
            end
            S_WR_PULSE: begin
                ram_ce_n = 1'b0;
                ram_be_n = ~be_q;
                ram_we_n = ~(|be_q);  // no strobe when no byte is enabled
                drive_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_addr   = addr_q;
    assign ram_data   = drive_en ? wdata_q : {DATA_W{1'bz}};
    assign inst_ack   = (state_q == S_DONE) && (owner_q == OWN_INST);
    assign data_ack   = (state_q == S_DONE) && (owner_q == OWN_DATA);
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with WAIT_CYCLES = 1 and a behavioural
// asynchronous SRAM. Honours SRAM_ARB_FAIR_EN for the starvation expectation.
module tb_sram_arbiter;

    localparam int W  = 1;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef SRAM_ARB_FAIR_EN
    localparam int EXP_DATA_BEFORE_INST = 4;
`else
    localparam int EXP_DATA_BEFORE_INST = 8;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req, inst_ack;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_we, data_ack;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata, data_rdata;
    logic [BW-1:0] data_be;
    wire  [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be_n;
    logic          ram_ce_n, ram_oe_n, ram_we_n;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .WAIT_CYCLES (W), .STARVE_LIMIT (4)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .inst_req (inst_req), .inst_addr (inst_addr),
        .inst_ack (inst_ack), .inst_rdata (inst_rdata),
        .data_req (data_req), .data_we (data_we), .data_addr (data_addr),
        .data_wdata (data_wdata), .data_be (data_be),
        .data_ack (data_ack), .data_rdata (data_rdata),
        .ram_data (ram_data), .ram_addr (ram_addr), .ram_be_n (ram_be_n),
        .ram_ce_n (ram_ce_n), .ram_oe_n (ram_oe_n), .ram_we_n (ram_we_n)
    );

    // ---------------- behavioural SRAM ----------------
    logic [31:0] sram    [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit          model_ready = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            'h123:   return 32'hDEADBEEF;
            'h010:   return 32'hAAAAAAAA;
            'h020:   return 32'h55667788;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Released bus reads as all ones, so a stray RTL drive is visible.
    for (genvar gi = 0; gi < DW; gi++) begin : g_pull
        pullup (ram_data[gi]);
    end

    assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[9:0]] : 32'bz;

    always @(posedge clk) begin
        if (!model_ready) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
            model_ready <= 1'b1;
        end else if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) sram[ram_addr[9:0]][8*b +: 8] <= ram_data[8*b +: 8];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request sampled at the next clock edge (edge 0); window w is
    // the interval between edges w and w+1, observed on the falling edge.
    task automatic run_access(input bit is_inst, input bit we, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output int ack_win, output int oe_cnt, output int we_cnt,
                              output logic [3:0] be_n_w1, output logic [31:0] rdata,
                              output int stray);
        ack_win = -1; oe_cnt = 0; we_cnt = 0; stray = 0; be_n_w1 = '1; rdata = '0;
        if (is_inst) begin
            inst_req = 1'b1; inst_addr = addr;
        end else begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata; data_be = be;
        end
        for (int w = 0; w < 40 && ack_win < 0; w++) begin
            @(negedge clk);
            if (!ram_oe_n) oe_cnt++;
            if (!ram_we_n) we_cnt++;
            if (w == 1) be_n_w1 = ram_be_n;
            if (is_inst ? data_ack : inst_ack) stray++;
            if (is_inst ? inst_ack : data_ack) begin
                ack_win = w;
                rdata   = is_inst ? inst_rdata : data_rdata;
            end
            if (w == 0) begin
                // Changing inputs after the grant must not affect the access.
                inst_addr = ~addr; data_addr = ~addr; data_wdata = ~wdata;
                data_be = ~be; data_we = ~we;
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        if (inst_ack || data_ack) stray++;
        txn++;
        $display("txn %0d: %s %s addr=%05h wdata=%08h be=%b ack@%0d rdata=%08h",
                 txn, is_inst ? "inst" : "data", we ? "WR" : "RD", addr, wdata, be,
                 ack_win, rdata);
    endtask

    typedef struct {
        bit          is_inst;
        bit          we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_ack;
        int          exp_oe;
        int          exp_we;
        logic [3:0]  exp_be_n;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int          ack_w, oe_c, we_c, stray;
    logic [3:0]  ben;
    logic [31:0] rd;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 20'h00123, 32'h0,        4'b0000, 32'hDEADBEEF, 3, 2, 0, 4'b0000};
        vecs[1] = '{1'b0, 1'b1, 20'h00010, 32'h11223344, 4'b0101, 32'h0,        5, 0, 2, 4'b1010};
        vecs[2] = '{1'b0, 1'b0, 20'h00010, 32'h0,        4'b1111, 32'hAA22AA44, 3, 2, 0, 4'b0000};
        vecs[3] = '{1'b0, 1'b1, 20'h00020, 32'h99999999, 4'b0000, 32'h0,        5, 0, 0, 4'b1111};
        vecs[4] = '{1'b0, 1'b0, 20'h00020, 32'h0,        4'b1111, 32'h55667788, 3, 2, 0, 4'b0000};
        vecs[5] = '{1'b0, 1'b1, 20'h00030, 32'hCAFEF00D, 4'b1111, 32'h0,        5, 0, 2, 4'b0000};
        vecs[6] = '{1'b1, 1'b0, 20'h00030, 32'h0,        4'b0000, 32'hCAFEF00D, 3, 2, 0, 4'b0000};
        vecs[7] = '{1'b0, 1'b1, 20'h00031, 32'h12345678, 4'b1000, 32'h0,        5, 0, 2, 4'b0111};
        vecs[8] = '{1'b0, 1'b0, 20'h00031, 32'h0,        4'b1111, 32'h12000000, 3, 2, 0, 4'b0000};
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        rst_n = 1'b0;
        inst_req = 0; inst_addr = '0; data_req = 0; data_we = 0;
        data_addr = '0; data_wdata = '0; data_be = '0;
        #2;
        check("rst ce_n", 32'(ram_ce_n), 32'd1);
        check("rst oe_n", 32'(ram_oe_n), 32'd1);
        check("rst we_n", 32'(ram_we_n), 32'd1);
        check("rst be_n", 32'(ram_be_n), 32'hF);
        check("rst addr", 32'(ram_addr), 32'h0);
        check("rst ram_data released", ram_data, 32'hFFFFFFFF);
        check("rst acks", {30'd0, inst_ack, data_ack}, 32'd0);
        check("rst inst_rdata", inst_rdata, 32'h0);
        check("rst data_rdata", data_rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            run_access(vecs[i].is_inst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                       ack_w, oe_c, we_c, ben, rd, stray);
            check($sformatf("vec%0d ack_window", i), 32'(ack_w), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d oe_low_cycles", i), 32'(oe_c), 32'(vecs[i].exp_oe));
            check($sformatf("vec%0d we_low_cycles", i), 32'(we_c), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d be_n", i), 32'(ben), 32'(vecs[i].exp_be_n));
            check($sformatf("vec%0d stray_acks", i), 32'(stray), 32'd0);
            if (!vecs[i].we)
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            else
                ref_mem[vecs[i].addr[9:0]] = merge(ref_mem[vecs[i].addr[9:0]], vecs[i].wdata,
                                                   vecs[i].be);
        end
        check("inst_rdata holds across data reads", inst_rdata, 32'hCAFEF00D);

        // ---------------- simultaneous requests ----------------
        begin
            int d_win, i_win, overlap;
            d_win = -1; i_win = -1; overlap = 0;
            inst_req = 1; inst_addr = 20'h00123;
            data_req = 1; data_we = 0; data_addr = 20'h00010; data_be = 4'hF;
            for (int w = 0; w < 40 && (d_win < 0 || i_win < 0); w++) begin
                @(negedge clk);
                if (inst_ack && data_ack) overlap++;
                if (data_ack) begin d_win = w; data_req = 0; end
                if (inst_ack) begin i_win = w; inst_req = 0; end
            end
            inst_req = 0; data_req = 0;
            $display("txn conflict: data ack@%0d inst ack@%0d", d_win, i_win);
            check("conflict data ack_window", 32'(d_win), 32'd3);
            check("conflict inst ack_window", 32'(i_win), 32'd8);
            check("conflict overlap", 32'(overlap), 32'd0);
            check("conflict data_rdata", data_rdata, 32'hAA22AA44);
            check("conflict inst_rdata", inst_rdata, 32'hDEADBEEF);
            @(negedge clk);
        end

        // ---------------- starvation ----------------
        begin
            int d_cnt, at_inst, overlap;
            bit inst_done;
            d_cnt = 0; at_inst = -1; overlap = 0; inst_done = 0;
            inst_req = 1; inst_addr = 20'h00123;
            data_req = 1; data_we = 0; data_addr = 20'h00010; data_be = 4'hF;
            for (int w = 0; w < 300 && !(inst_done && !data_req); w++) begin
                @(negedge clk);
                if (inst_ack && data_ack) overlap++;
                if (data_ack) begin
                    d_cnt++;
                    if (inst_done || d_cnt >= 8) data_req = 0;
                end
                if (inst_ack) begin
                    inst_done = 1; inst_req = 0; at_inst = d_cnt;
                end
            end
            inst_req = 0; data_req = 0;
            $display("txn starve: inst acked after %0d data grants", at_inst);
            check("starve inst acked", 32'(inst_done), 32'd1);
            check("starve data grants before inst", 32'(at_inst), 32'(EXP_DATA_BEFORE_INST));
            check("starve overlap", 32'(overlap), 32'd0);
            repeat (2) @(negedge clk);
        end

        // ---------------- reset during the write strobe ----------------
        begin
            int late_acks;
            late_acks = 0;
            data_req = 1; data_we = 1; data_addr = 20'h00040;
            data_wdata = 32'h0BADF00D; data_be = 4'hF;
            repeat (3) @(negedge clk);
            check("midrst we_n low before reset", 32'(ram_we_n), 32'd0);
            rst_n = 0; data_req = 0;
            #1;
            check("midrst ce_n", 32'(ram_ce_n), 32'd1);
            check("midrst oe_n", 32'(ram_oe_n), 32'd1);
            check("midrst we_n", 32'(ram_we_n), 32'd1);
            check("midrst be_n", 32'(ram_be_n), 32'hF);
            check("midrst addr", 32'(ram_addr), 32'h0);
            check("midrst ram_data released", ram_data, 32'hFFFFFFFF);
            repeat (2) begin
                @(negedge clk);
                if (inst_ack || data_ack) late_acks++;
            end
            rst_n = 1;
            repeat (6) begin
                @(negedge clk);
                if (inst_ack || data_ack) late_acks++;
            end
            $display("txn reset: write to 00040 abandoned");
            check("midrst no ack", 32'(late_acks), 32'd0);
            run_access(1'b1, 1'b0, 20'h00123, 32'h0, 4'h0, ack_w, oe_c, we_c, ben, rd, stray);
            check("post-reset read ack_window", 32'(ack_w), 32'd3);
            check("post-reset read rdata", rd, 32'hDEADBEEF);
        end

        // ---------------- randomized against reference ----------------
        for (int n = 0; n < 40; n++) begin
            bit          r_inst, r_we;
            logic [19:0] r_addr;
            logic [31:0] r_wd;
            logic [3:0]  r_be;
            r_inst = ($urandom_range(0, 2) == 0);
            r_we   = !r_inst && ($urandom_range(0, 1) == 1);
            r_addr = 20'($urandom_range(0, 63));
            r_wd   = $urandom;
            r_be   = 4'($urandom_range(0, 15));
            run_access(r_inst, r_we, r_addr, r_wd, r_be, ack_w, oe_c, we_c, ben, rd, stray);
            check($sformatf("rnd%0d stray_acks", n), 32'(stray), 32'd0);
            if (r_we) begin
                ref_mem[r_addr[9:0]] = merge(ref_mem[r_addr[9:0]], r_wd, r_be);
                check($sformatf("rnd%0d ack_window", n), 32'(ack_w), 32'(W + 4));
                check($sformatf("rnd%0d we_low_cycles", n), 32'(we_c),
                      32'((r_be != 0) ? W + 1 : 0));
            end else begin
                check($sformatf("rnd%0d ack_window", n), 32'(ack_w), 32'(W + 2));
                check($sformatf("rnd%0d rdata", n), rd, ref_mem[r_addr[9:0]]);
            end
        end

        // Final memory contents against the reference.
        for (int a = 0; a < 64; a++)
            check($sformatf("mem[%0d]", a), sram[a], ref_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
